// File: rtl/if_id_buffer.sv
// Fetch-to-decode pipeline buffer: 2-entry skid FIFO holding {instr, pc, pc+4}
// with a one-cycle flush for redirects and the fetch PC write enable.
module if_id_buffer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            ID_CLK,
  input  logic            ID_RST_N,
  input  logic            IF_VALID,
  input  logic [XLEN-1:0] MEM_INSTR,
  input  logic [XLEN-1:0] PC_COUNT,
  input  logic [XLEN-1:0] PC_PLUS_FOUR,
  input  logic            ID_STALL,
  input  logic            FLUSH,
  output logic            IF_READY,
  output logic            PC_WRITE,
  output logic            ID_VALID,
  output logic [XLEN-1:0] ID_INSTR,
  output logic [XLEN-1:0] ID_PC,
  output logic [XLEN-1:0] ID_PC_PLUS_FOUR
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_wp;
  logic            r_rp;
  logic            w_wp_nxt;
  logic            w_rp_nxt;
  logic            w_enq;
  logic            w_deq;
  logic [XLEN-1:0] r_instr [2];
  logic [XLEN-1:0] r_pc    [2];
  logic [XLEN-1:0] r_pc4   [2];

  // Ready depends on registered state only, so fetch never sees a loop through IF_VALID.
  assign IF_READY        = (r_state != S_FULL);
  assign ID_VALID        = (r_state != S_EMPTY);
  assign PC_WRITE        = (IF_READY & ~ID_STALL) | FLUSH;
  assign w_enq           = IF_VALID & IF_READY & ~FLUSH;
  assign w_deq           = ID_VALID & ~ID_STALL & ~FLUSH;
  assign ID_INSTR        = r_instr[r_rp];
  assign ID_PC           = r_pc[r_rp];
  assign ID_PC_PLUS_FOUR = r_pc4[r_rp];

  always_comb begin
    w_state_nxt = r_state;
    w_wp_nxt    = r_wp;
    w_rp_nxt    = r_rp;
    if (w_enq) w_wp_nxt = ~r_wp;
    if (w_deq) w_rp_nxt = ~r_rp;
    case (r_state)
      S_EMPTY: if (w_enq) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_enq && !w_deq)      w_state_nxt = S_FULL;
        else if (!w_enq && w_deq) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_deq) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
    // Redirect empties the buffer without touching stored entries.
    if (FLUSH) begin
      w_state_nxt = S_EMPTY;
      w_wp_nxt    = 1'b0;
      w_rp_nxt    = 1'b0;
    end
  end

  always_ff @(posedge ID_CLK) begin
    if (!ID_RST_N) begin
      r_state <= S_EMPTY;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_pc4[i]   <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_wp    <= w_wp_nxt;
      r_rp    <= w_rp_nxt;
      if (w_enq) begin
        r_instr[r_wp] <= MEM_INSTR;
        r_pc[r_wp]    <= PC_COUNT;
        r_pc4[r_wp]   <= PC_PLUS_FOUR;
      end
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] mem_instr;
  logic [31:0] pc_count;
  logic [31:0] pc_plus_four;
  logic        id_stall;
  logic        flush;
  logic        if_ready;
  logic        pc_write;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  int checks = 0;
  int errors = 0;

  if_id_buffer #(.XLEN(32)) dut (
    .ID_CLK          (clk),
    .ID_RST_N        (rst_n),
    .IF_VALID        (if_valid),
    .MEM_INSTR       (mem_instr),
    .PC_COUNT        (pc_count),
    .PC_PLUS_FOUR    (pc_plus_four),
    .ID_STALL        (id_stall),
    .FLUSH           (flush),
    .IF_READY        (if_ready),
    .PC_WRITE        (pc_write),
    .ID_VALID        (id_valid),
    .ID_INSTR        (id_instr),
    .ID_PC           (id_pc),
    .ID_PC_PLUS_FOUR (id_pc4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
    if_valid     = v;
    mem_instr    = ins;
    pc_count     = pc;
    pc_plus_four = pc + 32'd4;
    id_stall     = st;
    flush        = fl;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_instr"}, id_instr, ins);
    chk({tag, "_pc4"}, id_pc4, pc + 32'd4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_ready"}, 32'(if_ready), 32'd1);
    chk({tag, "_instr"}, id_instr, 32'd0);
    chk({tag, "_pc"}, id_pc, 32'd0);
    chk({tag, "_pc4"}, id_pc4, 32'd0);
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'h0A00_0000 | pc;
  endfunction

  initial begin
    logic [31:0] q[$];
    logic [31:0] wpc;
    int          sent;
    int          got;
    int          mcount;
    logic        st;
    logic        en;
    logic        de;

    // Reset held for two edges
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk_reset("reset");
    chk("reset_pcwrite", 32'(pc_write), 32'd1);

    // Streaming: 1-cycle latency, one entry per cycle
    rst_n = 1'b1;
    drive(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stream_pre_valid", 32'(id_valid), 32'd0);
    tick();
    chk_head("stream0", 32'h0000_0013, 32'h0);
    drive(1'b1, 32'h0010_0093, 32'h4, 1'b0, 1'b0);
    tick();
    chk_head("stream1", 32'h0010_0093, 32'h4);

    // Stall fill: 0x8 absorbed into second entry, head holds 0x4
    drive(1'b1, 32'h0020_0113, 32'h8, 1'b1, 1'b0);
    #1;
    chk("stall_pcwrite0", 32'(pc_write), 32'd0);
    tick();
    chk_head("stall_a", 32'h0010_0093, 32'h4);
    chk("stall_full_ready", 32'(if_ready), 32'd0);
    drive(1'b1, ins_of(32'hC), 32'hC, 1'b1, 1'b0);
    #1;
    chk("stall_pcwrite1", 32'(pc_write), 32'd0);
    tick();
    chk_head("stall_b", 32'h0010_0093, 32'h4);
    tick();
    chk_head("stall_c", 32'h0010_0093, 32'h4);
    chk("stall_c_ready", 32'(if_ready), 32'd0);
    drive(1'b1, ins_of(32'hC), 32'hC, 1'b0, 1'b0);
    #1;
    chk("release_pcwrite", 32'(pc_write), 32'd0);
    tick();
    chk_head("release_a", 32'h0020_0113, 32'h8);
    chk("release_ready", 32'(if_ready), 32'd1);
    tick();
    chk_head("release_b", ins_of(32'hC), 32'hC);

    // Memory busy bubble
    drive(1'b0, 32'd0, 32'h10, 1'b0, 1'b0);
    tick();
    chk("busy_drain_valid", 32'(id_valid), 32'd0);
    tick();
    chk("busy_hold_valid", 32'(id_valid), 32'd0);
    drive(1'b1, ins_of(32'h10), 32'h10, 1'b0, 1'b0);
    tick();
    chk_head("busy_resume", ins_of(32'h10), 32'h10);

    // Flush while full: 0x18 is dropped, 0x100 follows with 1-cycle latency
    drive(1'b1, ins_of(32'h14), 32'h14, 1'b1, 1'b0);
    tick();
    chk_head("flush_full", ins_of(32'h10), 32'h10);
    chk("flush_full_ready", 32'(if_ready), 32'd0);
    drive(1'b1, ins_of(32'h18), 32'h18, 1'b0, 1'b1);
    #1;
    chk("flush_pcwrite", 32'(pc_write), 32'd1);
    tick();
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_ready", 32'(if_ready), 32'd1);
    drive(1'b1, ins_of(32'h100), 32'h100, 1'b0, 1'b0);
    tick();
    chk_head("redirect", ins_of(32'h100), 32'h100);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("redirect_drain", 32'(id_valid), 32'd0);

    // Reset while full and stalled
    drive(1'b1, ins_of(32'h200), 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, ins_of(32'h204), 32'h204, 1'b1, 1'b0);
    tick();
    chk("prereset_ready", 32'(if_ready), 32'd0);
    chk_head("prereset", ins_of(32'h200), 32'h200);
    rst_n = 1'b0;
    drive(1'b1, ins_of(32'h208), 32'h208, 1'b1, 1'b0);
    tick();
    chk_reset("midreset");
    chk("midreset_pcwrite_stalled", 32'(pc_write), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, ins_of(32'h300), 32'h300, 1'b0, 1'b0);
    #1;
    chk("midreset_pcwrite", 32'(pc_write), 32'd1);
    tick();
    chk_head("postreset", ins_of(32'h300), 32'h300);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("postreset_drain", 32'(id_valid), 32'd0);

    // Wrap-around: 7 words, stall every 3rd cycle, order checked by scoreboard
    sent   = 0;
    got    = 0;
    mcount = 0;
    for (int cyc = 0; cyc < 40 && got < 7; cyc++) begin
      st  = ((cyc % 3) == 2);
      wpc = 32'h400 + 32'(sent * 4);
      drive(sent < 7, ins_of(wpc), wpc, st, 1'b0);
      #1;
      chk("wrap_valid", 32'(id_valid), 32'(mcount != 0));
      chk("wrap_ready", 32'(if_ready), 32'(mcount != 2));
      en = (sent < 7) && (mcount != 2);
      de = (mcount != 0) && !st;
      if (de) begin
        chk("wrap_pc", id_pc, q[0]);
        chk("wrap_instr", id_instr, ins_of(q[0]));
        void'(q.pop_front());
        got++;
      end
      if (en) begin
        q.push_back(wpc);
        sent++;
      end
      mcount = mcount + int'(en) - int'(de);
      tick();
    end
    chk("wrap_count", 32'(got), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Fetch-to-decode pipeline buffer for the Otter pipeline. Captures each valid instruction word from instruction memory, with its PC and PC+4, into a 2-entry skid FIFO and presents the oldest entry to the decode stage. Produces the fetch-stage PC write enable, so that fetch stalls when the buffer is full or decode is stalled. Redirects from branch, JAL or JALR are handled by a one-cycle flush.

## Interface
- XLEN, 32, data/address width.
- ID_CLK  in  1  pipeline clock; all state updates on its rising edge.
- ID_RST_N  in  1  reset; synchronous, active-low.
- IF_VALID  in  1  instruction word on MEM_INSTR is valid this cycle; equals the inverse of the registered memory-busy flag.
- MEM_INSTR  in  XLEN  instruction word from instruction memory.
- PC_COUNT  in  XLEN  address of MEM_INSTR.
- PC_PLUS_FOUR  in  XLEN  PC_COUNT+4 from fetch.
- ID_STALL  in  1  decode cannot consume the head entry this cycle.
- FLUSH  in  1  redirect; discard all buffered and incoming entries.
- IF_READY  out  1  buffer can accept an entry this cycle.
- PC_WRITE  out  1  fetch PC write enable; equals IF_READY & ~ID_STALL | FLUSH.
- ID_VALID  out  1  head entry valid.
- ID_INSTR  out  XLEN  head instruction word.
- ID_PC  out  XLEN  head PC.
- ID_PC_PLUS_FOUR  out  XLEN  head PC+4.

## Operation
- Storage: 2 entries of {instr, pc, pc+4}, with a 1-bit write pointer (wp), a 1-bit read pointer (rp) and a count.
- State machine, encoded by count:
  - EMPTY: count=0.
  - ONE: count=1.
  - FULL: count=2.
- Handshake signals:
  - enq = IF_VALID & IF_READY & ~FLUSH.
  - deq = ID_VALID & ~ID_STALL & ~FLUSH.
  - IF_READY = (count != 2), decoded from registered state only (no combinational path from IF_VALID).
- Transitions:
  - EMPTY: enq → ONE.
  - ONE: enq & ~deq → FULL; deq & ~enq → EMPTY; enq & deq → ONE.
  - FULL: deq → ONE. Enq is impossible because IF_READY=0.
- Pointer updates:
  - On enq: write entry[wp], then wp^=1.
  - On deq: rp^=1.
  - Both pointers wrap modulo 2.
- Outputs:
  - ID_VALID = (count != 0).
  - ID_INSTR, ID_PC and ID_PC_PLUS_FOUR = entry[rp]. Their values are don't-care when ID_VALID=0, but must not be X after reset.
- FLUSH has priority over everything:
  - Next state is EMPTY, wp=rp=0.
  - The same-cycle IF_VALID word is dropped.
  - The head is not consumed.
  - Entry storage is not cleared.
- Reset (ID_RST_N=0 at a clock edge) has priority over FLUSH:
  - count=0, wp=rp=0, all entry fields cleared to 0.
  - Reset may assert in any state; in-flight entries are lost.
- Pass-through data: no arithmetic on PC values; PC_PLUS_FOUR is stored as given and not recomputed.

## Timing
- Latency: a word accepted at edge N appears on ID_* with ID_VALID=1 after edge N when the buffer was EMPTY (1-cycle latency).
- Throughput: 1 entry per cycle with no stalls. Steady state is ONE, with simultaneous enq and deq.
- Stall absorption:
  - ID_STALL raised with count=1: the next fetched word is absorbed into entry 2 (FULL), then IF_READY=0.
  - PC_WRITE is low in any cycle with ID_STALL=1 and FLUSH=0, so fetch does not advance beyond the buffer's capacity.
- IF_VALID=0 (memory busy): no enq. The head remains valid and consumable.
- Output values after reset: ID_VALID=0, IF_READY=1, PC_WRITE=1, ID_INSTR=ID_PC=ID_PC_PLUS_FOUR=0.
- FLUSH at edge N: ID_VALID=0 after edge N. The first post-redirect word can be accepted in cycle N+1.

## Test plan
- Reset then streaming:
  - Stimulus: hold ID_RST_N=0 for 2 cycles and check all outputs equal the reset values; then present IF_VALID=1 with PCs 0x0, 0x4, 0x8 and MEM_INSTR 0x00000013, 0x00100093, 0x00200113, ID_STALL=0.
  - Required: ID_VALID rises one cycle after the first word; ID_PC reads 0x0, 0x4, 0x8 on consecutive cycles with matching instructions and ID_PC_PLUS_FOUR.
- Stall fill:
  - Stimulus: stream as above, then assert ID_STALL for 3 cycles.
  - Required: head holds PC 0x4; count reaches 2; IF_READY=0 and PC_WRITE=0; after stall release, PC 0x4 then 0x8 appear in order with no loss or duplication.
- Memory busy bubble:
  - Stimulus: IF_VALID=0 for 2 cycles mid-stream.
  - Required: ID_VALID drops after the buffer drains; PC sequence has no gaps or repeats when IF_VALID returns.
- Flush while full:
  - Stimulus: reach count=2 with PCs 0x10 and 0x14, then FLUSH=1 with IF_VALID=1 at PC 0x18.
  - Required: ID_VALID=0 next cycle; 0x18 is never presented; the next word at PC 0x100 appears with 1-cycle latency.
- Reset mid-operation:
  - Stimulus: ID_RST_N=0 while FULL with ID_STALL=1.
  - Required: outputs return to reset values; the first word after reset is presented at the head.
- Wrap-around:
  - Stimulus: 7 alternating enq and deq operations with stalls injected every 3rd cycle.
  - Required: output order matches input order across pointer wrap; the scoreboard matches all 7 PCs.
